// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: tms-steered state machine with registered,
// glitch-free control strobes and a saturating Run-Test/Idle cycle counter.
module tap_controller #(
    parameter int RTI_CNT_W = 16
) (
    input  logic                 tck,
    input  logic                 rst,
    input  logic                 tms,
    output logic                 tl_reset,
    output logic                 captureIR,
    output logic                 shiftIR,
    output logic                 updateIR,
    output logic                 captureDR,
    output logic                 shiftDR,
    output logic                 updateDR,
    output logic                 sel_ir,
    output logic                 tdo_en,
    output logic [3:0]           tap_state,
    output logic [RTI_CNT_W-1:0] rti_count
);

    typedef enum logic [3:0] {
        EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3,
        SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
        EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB,
        RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
    } tap_state_e;

    localparam logic [RTI_CNT_W-1:0] RTI_MAX = '1;
    localparam logic [RTI_CNT_W-1:0] RTI_ONE = RTI_CNT_W'(1);

    tap_state_e state_q;
    tap_state_e state_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = TLR;
        case (state_q)
            TLR:    state_d = tms ? TLR    : RTI;
            RTI:    state_d = tms ? SEL_DR : RTI;
            SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms ? SEL_DR : RTI;
            SEL_IR: state_d = tms ? TLR    : CAP_IR;
            CAP_IR: state_d = tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Strobes are decoded from the next state so they flip on the same edge
    // as tap_state, straight out of flops.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge tck) begin
        if (rst) begin
            state_q   <= TLR;
            tl_reset  <= 1'b0;
            captureIR <= 1'b0;
            shiftIR   <= 1'b0;
            updateIR  <= 1'b0;
            captureDR <= 1'b0;
            shiftDR   <= 1'b0;
            updateDR  <= 1'b0;
            sel_ir    <= 1'b0;
            tdo_en    <= 1'b0;
            rti_count <= '0;
        end else begin
            state_q   <= state_d;
            tl_reset  <= (state_d != TLR);
            captureIR <= (state_d == CAP_IR);
            shiftIR   <= (state_d == SH_IR);
            updateIR  <= (state_d == UPD_IR);
            captureDR <= (state_d == CAP_DR);
            shiftDR   <= (state_d == SH_DR);
            updateDR  <= (state_d == UPD_DR);
            sel_ir    <= (state_d inside {SEL_IR, CAP_IR, SH_IR, EX1_IR,
                                          PAU_IR, EX2_IR, UPD_IR});
            tdo_en    <= (state_d == SH_IR) || (state_d == SH_DR);
            // Counter restarts on RTI entry, saturates, and holds elsewhere.
            if (state_d == RTI) begin
                if (state_q != RTI)
                    rti_count <= '0;
                else if (rti_count != RTI_MAX)
                    rti_count <= rti_count + RTI_ONE;
            end
        end
    end

    assign tap_state = state_q;

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: a reference TAP model feeds a
// scoreboard queue that is compared against two DUTs (RTI_CNT_W = 3 and 16).
module tb_tap_controller;

    logic tck = 1'b0;
    logic rst = 1'b1;
    logic tms = 1'b0;

    logic       tl_reset, captureIR, shiftIR, updateIR;
    logic       captureDR, shiftDR, updateDR, sel_ir, tdo_en;
    logic [3:0] tap_state;
    logic [2:0] rti_count;

    logic        tl_reset_b, captureIR_b, shiftIR_b, updateIR_b;
    logic        captureDR_b, shiftDR_b, updateDR_b, sel_ir_b, tdo_en_b;
    logic [3:0]  tap_state_b;
    logic [15:0] rti_count_b;

    int n_checks = 0;
    int n_errors = 0;

    tap_controller #(.RTI_CNT_W(3)) dut (
        .tck(tck), .rst(rst), .tms(tms),
        .tl_reset(tl_reset), .captureIR(captureIR), .shiftIR(shiftIR),
        .updateIR(updateIR), .captureDR(captureDR), .shiftDR(shiftDR),
        .updateDR(updateDR), .sel_ir(sel_ir), .tdo_en(tdo_en),
        .tap_state(tap_state), .rti_count(rti_count)
    );

    tap_controller dut16 (
        .tck(tck), .rst(rst), .tms(tms),
        .tl_reset(tl_reset_b), .captureIR(captureIR_b), .shiftIR(shiftIR_b),
        .updateIR(updateIR_b), .captureDR(captureDR_b), .shiftDR(shiftDR_b),
        .updateDR(updateDR_b), .sel_ir(sel_ir_b), .tdo_en(tdo_en_b),
        .tap_state(tap_state_b), .rti_count(rti_count_b)
    );

    always #5 tck = ~tck;

    typedef struct {
        logic [3:0] st;
        logic [8:0] outs;
        int         rti3;
        int         rti16;
    } exp_t;

    exp_t sb[$];

    logic [3:0] m_st = 4'hF;
    int m_rti3 = 0;
    int m_rti16 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_next(input logic [3:0] s, input logic t);
        case (s)
            4'hF: return t ? 4'hF : 4'hC;
            4'hC: return t ? 4'h7 : 4'hC;
            4'h7: return t ? 4'h4 : 4'h6;
            4'h4: return t ? 4'hF : 4'hE;
            4'h6: return t ? 4'h1 : 4'h2;
            4'h2: return t ? 4'h1 : 4'h2;
            4'h1: return t ? 4'h5 : 4'h3;
            4'h3: return t ? 4'h0 : 4'h3;
            4'h0: return t ? 4'h5 : 4'h2;
            4'h5: return t ? 4'h7 : 4'hC;
            4'hE: return t ? 4'h9 : 4'hA;
            4'hA: return t ? 4'h9 : 4'hA;
            4'h9: return t ? 4'hD : 4'hB;
            4'hB: return t ? 4'h8 : 4'hB;
            4'h8: return t ? 4'hD : 4'hA;
            4'hD: return t ? 4'h7 : 4'hC;
            default: return 4'hF;
        endcase
    endfunction

    // {tl_reset, captureIR, shiftIR, updateIR, captureDR, shiftDR, updateDR, sel_ir, tdo_en}
    function automatic logic [8:0] model_outs(input logic [3:0] s);
        logic ir_col;
        ir_col = (s == 4'h4) || (s == 4'hE) || (s == 4'hA) || (s == 4'h9) ||
                 (s == 4'hB) || (s == 4'h8) || (s == 4'hD);
        return {s != 4'hF, s == 4'hE, s == 4'hA, s == 4'hD,
                s == 4'h6, s == 4'h2, s == 4'h5, ir_col,
                (s == 4'hA) || (s == 4'h2)};
    endfunction

    function automatic int rti_next(input int cur, input logic [3:0] prev,
                                    input logic [3:0] nx, input int max);
        if (nx != 4'hC) return cur;
        if (prev != 4'hC) return 0;
        return (cur == max) ? cur : cur + 1;
    endfunction

    // Drive one tck cycle, queue the model's expectation, then compare after the edge.
    task automatic step(input logic t, input logic r);
        exp_t e;
        logic [3:0] nx;
        @(negedge tck);
        tms = t;
        rst = r;
        nx = r ? 4'hF : model_next(m_st, t);
        if (r) begin
            m_rti3 = 0;
            m_rti16 = 0;
        end else begin
            m_rti3 = rti_next(m_rti3, m_st, nx, 7);
            m_rti16 = rti_next(m_rti16, m_st, nx, 65535);
        end
        m_st = nx;
        e.st = m_st;
        e.outs = model_outs(m_st);
        e.rti3 = m_rti3;
        e.rti16 = m_rti16;
        sb.push_back(e);
        @(posedge tck);
        #1;
        e = sb.pop_front();
        check("state", 32'(tap_state), 32'(e.st));
        check("outs", 32'({tl_reset, captureIR, shiftIR, updateIR, captureDR,
                           shiftDR, updateDR, sel_ir, tdo_en}), 32'(e.outs));
        check("rti3", 32'(rti_count), e.rti3);
        check("state16", 32'(tap_state_b), 32'(e.st));
        check("rti16", 32'(rti_count_b), e.rti16);
    endtask

    task automatic seq(input logic [15:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) step(bits[i], 1'b0);
    endtask

    initial begin
        int n;

        // Reset, then RTI entry.
        step(1'b0, 1'b1);
        check("rst_tlreset", 32'(tl_reset), 32'd0);
        step(1'b0, 1'b0);
        check("rti_entry", 32'({tap_state, tl_reset}), 32'h19);

        // IR scan: 1,1,0,0,0,0,1,1,0
        seq(16'b110000110, 9);
        check("ir_end", 32'(tap_state), 32'hC);

        // DR scan with pause: 1,0,0,1,0,0,1,0,1,1
        seq(16'b1001001011, 10);
        check("dr_upd", 32'({tap_state, updateDR}), 32'hB);
        step(1'b0, 1'b0);
        check("dr_upd_pulse", 32'(updateDR), 32'd0);

        // Five tms=1 from every state.
        for (int tgt = 0; tgt < 16; tgt++) begin
            step(1'b0, 1'b1);
            n = 0;
            while (m_st != 4'(tgt) && n < 2000) begin
                step(1'($urandom_range(0, 1)), 1'b0);
                n++;
            end
            check("reach", 32'(tap_state), 32'(tgt));
            repeat (5) step(1'b1, 1'b0);
            check("tlr5", 32'({tap_state, tl_reset}), 32'h1E);
        end

        // Reset in the middle of a DR shift.
        seq(16'b0100, 4);
        check("in_shdr", 32'({shiftDR, tdo_en}), 32'h3);
        step(1'b0, 1'b1);
        check("mid_rst", 32'({tap_state, shiftDR, tdo_en, tl_reset}), 32'h78);

        // RTI counter saturation, hold outside RTI, restart on re-entry.
        step(1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        check("rti_sat", 32'(rti_count), 32'd7);
        seq(16'b1011, 4);
        check("rti_hold", 32'(rti_count), 32'd7);
        step(1'b0, 1'b0);
        check("rti_reentry", 32'(rti_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
